// File: rtl/dm74ls194_if.sv
// Mode, data and serial inputs plus the four register outputs of
// the 74LS194-style shift register, bundled for the register cell.
interface dm74ls194_if;
    logic S1;
    logic S0;
    logic A;
    logic B;
    logic C;
    logic D;
    logic SL;
    logic SR;
    logic QA;
    logic QB;
    logic QC;
    logic QD;

    modport master (
        output S1, S0, A, B, C, D, SL, SR,
        input  QA, QB, QC, QD
    );

    modport slave (
        input  S1, S0, A, B, C, D, SL, SR,
        output QA, QB, QC, QD
    );
endinterface

// File: rtl/dm74ls194.sv
// 4-bit universal bidirectional shift register (74LS194 function):
// hold, shift right, shift left, parallel load; async active-low clear.
module dm74ls194 (
    input  logic        clk,
    input  logic        CR,
    dm74ls194_if.slave  bus
);

    // Packed as {QA,QB,QC,QD}: QA is the leftmost stage.
    logic [3:0] r_q;
    logic [3:0] w_nxt;
    logic [1:0] w_mode;

    assign w_mode = {bus.S1, bus.S0};

    always_comb begin
        w_nxt = r_q;
        case (w_mode)
            2'b00:   w_nxt = r_q;
            2'b01:   w_nxt = {bus.SR, r_q[3:1]};
            2'b10:   w_nxt = {r_q[2:0], bus.SL};
            2'b11:   w_nxt = {bus.A, bus.B, bus.C, bus.D};
            default: w_nxt = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge CR) begin
        if (!CR) begin
            r_q <= 4'b0000;
        end else begin
            r_q <= w_nxt;
        end
    end

    assign bus.QA = r_q[3];
    assign bus.QB = r_q[2];
    assign bus.QC = r_q[1];
    assign bus.QD = r_q[0];

endmodule

// File: tb/tb_dm74ls194.sv
// Directed, table-driven bench for the dm74ls194 shift register.
module tb_dm74ls194;

    logic clk;
    logic CR;
    int   checks;
    int   failures;

    dm74ls194_if bus ();

    dm74ls194 dut (
        .clk (clk),
        .CR  (CR),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cr;
        logic [1:0] mode;
        logic [3:0] par;
        logic       sl;
        logic       sr;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] q_now();
        return {bus.QA, bus.QB, bus.QC, bus.QD};
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = q_now();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got Q=%b expected Q=%b", name, got, exp);
        end
    endtask

    task automatic add(input logic cr, input logic [1:0] mode,
                       input logic [3:0] par, input logic sl,
                       input logic sr, input logic [3:0] exp);
        vec_t v;
        v.cr = cr;
        v.mode = mode;
        v.par = par;
        v.sl = sl;
        v.sr = sr;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        CR = v.cr;
        {bus.S1, bus.S0} = v.mode;
        {bus.A, bus.B, bus.C, bus.D} = v.par;
        bus.SL = v.sl;
        bus.SR = v.sr;
    endtask

    task automatic run_range(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), vecs[i].exp);
        end
    endtask

    initial begin
        int n0;
        int n1;
        checks = 0;
        failures = 0;

        // Shift right with SR=1 from cleared state
        add(1, 2'b01, 4'b0000, 0, 1, 4'b1000);
        add(1, 2'b01, 4'b0000, 0, 1, 4'b1100);
        add(1, 2'b01, 4'b0000, 0, 1, 4'b1110);
        add(1, 2'b01, 4'b0000, 0, 1, 4'b1111);
        add(1, 2'b01, 4'b0000, 0, 1, 4'b1111);
        n0 = vecs.size();
        // Clear held across an edge in shift-right mode
        add(0, 2'b01, 4'b1111, 1, 1, 4'b0000);
        // Shift left with SL=1, then SL=0
        add(1, 2'b10, 4'b0000, 1, 0, 4'b0001);
        add(1, 2'b10, 4'b0000, 1, 0, 4'b0011);
        add(1, 2'b10, 4'b0000, 1, 0, 4'b0111);
        add(1, 2'b10, 4'b0000, 1, 0, 4'b1111);
        add(1, 2'b10, 4'b0000, 0, 1, 4'b1110);
        // Load then hold with toggling data/serial inputs
        add(1, 2'b11, 4'b1000, 0, 0, 4'b1000);
        add(1, 2'b00, 4'b0111, 1, 1, 4'b1000);
        add(1, 2'b00, 4'b1010, 0, 1, 4'b1000);
        add(1, 2'b00, 4'b0101, 1, 0, 4'b1000);
        // Shift right with SR=0, load 0001, shift left SL=0
        add(1, 2'b01, 4'b1111, 1, 0, 4'b0100);
        add(1, 2'b01, 4'b1111, 1, 0, 4'b0010);
        add(1, 2'b01, 4'b1111, 1, 0, 4'b0001);
        add(1, 2'b01, 4'b1111, 1, 0, 4'b0000);
        add(1, 2'b11, 4'b0001, 1, 1, 4'b0001);
        add(1, 2'b10, 4'b1111, 0, 1, 4'b0010);
        // Clear beats parallel load, then load after release
        add(0, 2'b11, 4'b1111, 1, 1, 4'b0000);
        add(1, 2'b11, 4'b1111, 1, 1, 4'b1111);
        n1 = vecs.size();

        CR = 1'b0;
        bus.S1 = 1'b0;
        bus.S0 = 1'b0;
        {bus.A, bus.B, bus.C, bus.D} = 4'b0000;
        bus.SL = 1'b0;
        bus.SR = 1'b0;
        #1;
        check("reset", 4'b0000);

        run_range(0, n0, "shr");

        // Async clear from 1111 between edges
        @(negedge clk);
        #2;
        check("pre_clear_full", 4'b1111);
        CR = 1'b0;
        #1;
        check("async_clear", 4'b0000);

        run_range(n0, n0 + 14, "mix");

        // Input changes between edges must not disturb the outputs
        @(negedge clk);
        CR = 1'b1;
        {bus.S1, bus.S0} = 2'b11;
        {bus.A, bus.B, bus.C, bus.D} = 4'b1111;
        #1;
        check("between_edges", 4'b0000);
        {bus.A, bus.B, bus.C, bus.D} = 4'b0000;
        {bus.S1, bus.S0} = 2'b00;
        #1;
        check("between_edges2", 4'b0000);

        run_range(n0 + 14, n1, "tail");

        // Clear asserted mid-cycle then released: next edge reloads
        @(negedge clk);
        {bus.S1, bus.S0} = 2'b11;
        {bus.A, bus.B, bus.C, bus.D} = 4'b0110;
        CR = 1'b0;
        #1;
        check("clear_mid", 4'b0000);
        CR = 1'b1;
        @(posedge clk);
        #1;
        check("resume_load", 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm74ls194.md
Name: dm74ls194

Overview:
- 4-bit universal bidirectional shift register with the function of the classic 74LS194 part.
- Modes, selected by S1/S0: hold, shift right, shift left, synchronous parallel load.
- Asynchronous active-low clear.
- Used as a standalone register cell in logic/shift experiments; outputs drive LEDs or downstream logic directly.

Parameters:
- none (width fixed at 4 bits)

Ports:
- clk  input  1  clock; all state changes except clear occur on its rising edge
- CR  input  1  asynchronous active-low clear; 0 forces QA..QD to 0
- S1  input  1  mode select, high bit
- S0  input  1  mode select, low bit
- A  input  1  parallel data for QA
- B  input  1  parallel data for QB
- C  input  1  parallel data for QC
- D  input  1  parallel data for QD
- SL  input  1  serial input for shift left; enters at QD
- SR  input  1  serial input for shift right; enters at QA
- QA  output  1  register bit A (leftmost; first stage of a right shift)
- QB  output  1  register bit B
- QC  output  1  register bit C
- QD  output  1  register bit D (rightmost)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (CR).
- State: four flip-flops, QA..QD, registered outputs with no combinational path from inputs.
- Reset/clear:
  - CR=0 immediately forces QA=QB=QC=QD=0, independent of clk.
  - Clear has priority over every mode.
  - While CR=0, clock edges are ignored.
  - Clear deasserting mid-operation resumes normal operation at the next rising edge; no state is remembered from before the clear.
- On each rising clk edge with CR=1, the action is set by {S1,S0}:
  - 00 hold: QA..QD unchanged.
  - 01 shift right: QA<=SR, QB<=QA, QC<=QB, QD<=QC.
  - 10 shift left: QA<=QB, QB<=QC, QC<=QD, QD<=SL.
  - 11 parallel load: QA<=A, QB<=B, QC<=C, QD<=D.
- Input sampling:
  - Latency is one clock edge for every mode.
  - SR and SL are sampled only in their own shift mode; parallel inputs are sampled only in load mode.
- Input changes between edges have no effect on the outputs (CR excepted).
- Inputs are treated as synchronous to clk; the bench must not change S1/S0/data coincident with the rising edge.
- Power-up state is undefined until the first CR=0 pulse; the bench must apply clear first.

Test Plan:
1. Clear and shift right:
   - CR=0 at t=0 -> Q=0000 (QA..QD).
   - CR=1, S1S0=01, SR=1 -> after edges 1..4: 1000, 1100, 1110, 1111; 5th edge stays 1111.
2. Asynchronous clear from full:
   - With Q=1111, drop CR between edges -> Q=0000 immediately, without waiting for a clock edge.
   - Hold CR=0 across an edge with S1S0=01 -> Q stays 0000.
3. Shift left:
   - From 0000: CR=1, S1S0=10, SL=1 -> 0001, 0011, 0111, 1111 over four edges.
   - Then SL=0 -> 1110.
4. Parallel load and hold:
   - S1S0=11, A,B,C,D=1,0,0,0 -> 1000 after one edge.
   - S1S0=00 with data/serial inputs toggling -> 1000 held over three edges.
5. Load then shift right:
   - From 1000: S1S0=01, SR=0 -> 0100, 0010, 0001, 0000.
   - Then S1S0=11, A,B,C,D=0,0,0,1 -> 0001.
   - Then S1S0=10, SL=0 -> 0010.
6. Clear priority:
   - S1S0=11, A..D=1111, CR=0 across a rising edge -> Q=0000.
   - Release CR, next edge -> 1111.
